// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan-chain controller.
// Holds the FSM state type and its encoding width; the bit-counter width is
// derived locally in each user from CHAIN_LEN.
package scan_ctrl_pkg;

  localparam int unsigned SCAN_STATE_W = 3;

  typedef enum logic [SCAN_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_t;

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load / serial shift register with enable.
// Shifts toward the MSB; sin_i enters at bit 0, sout_o is the MSB.
// Ports:
//   clk_i       clock, all updates on posedge
//   rst_ni      synchronous active-low reset (clears the register)
//   load_i      parallel load of load_val_i (has priority over shift_i)
//   load_val_i  parallel load value
//   shift_i     shift enable
//   sin_i       serial input into bit 0
//   q_o         parallel contents
//   sout_o      serial output (MSB)
module scan_shreg
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (shift_i) begin
      q_q <= {q_q[WIDTH-2:0], sin_i};
    end
  end

  assign q_o    = q_q;
  assign sout_o = q_q[WIDTH-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-chain load / capture / unload sequencer.
// On an accepted start the pattern is shifted MSB first into a CHAIN_LEN-flop
// scan chain, one functional capture cycle is issued, and the chain is
// unloaded into result; done pulses for one cycle when result is complete.
// Ports:
//   CLK      sole clock
//   RSTB     synchronous active-low reset
//   start    begin a sequence (honoured only in IDLE)
//   abort    end the current sequence without done
//   pattern  stimulus, bit j targets chain flop j (flop 0 nearest SI)
//   SO       Q of the last chain flop
//   SE       scan enable to the chain (registered)
//   SI       scan data into flop 0 (registered)
//   busy     high in every state except IDLE (registered)
//   done     one-cycle completion pulse (registered)
//   result   captured response, bit j from flop j (registered)
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result
);

  localparam int unsigned         CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_t           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  se_q;
  logic                  si_q;
  logic                  busy_q;
  logic                  done_q;
  logic [CHAIN_LEN-1:0]  result_q;

  logic                  accept;
  logic                  abort_act;
  logic                  cnt_last;
  logic                  pat_load;
  logic [CHAIN_LEN-1:0]  pat_load_val;
  logic                  pat_shift;
  logic                  rsp_shift;
  logic [CHAIN_LEN-1:0]  pat_q;
  logic                  pat_sout;
  logic [CHAIN_LEN-1:0]  rsp_q;
  logic                  rsp_sout;
  logic                  unused_bits;

  always_comb begin
    accept       = (state_q == ST_IDLE) && start;
    abort_act    = (state_q != ST_IDLE) && abort;
    cnt_last     = (cnt_q == CNT_LAST);
    pat_load     = accept;
    // pattern MSB goes straight to SI on the start edge, so the register is
    // pre-shifted by one and its MSB always holds the next SI bit.
    pat_load_val = {pattern[CHAIN_LEN-2:0], 1'b0};
    pat_shift    = (state_q == ST_SHIFT) && !abort;
    rsp_shift    = (state_q == ST_UNLOAD) && !abort;
  end

  scan_shreg #(
    .WIDTH (CHAIN_LEN)
  ) u_pat_shreg (
    .clk_i      (CLK),
    .rst_ni     (RSTB),
    .load_i     (pat_load),
    .load_val_i (pat_load_val),
    .shift_i    (pat_shift),
    .sin_i      (1'b0),
    .q_o        (pat_q),
    .sout_o     (pat_sout)
  );

  scan_shreg #(
    .WIDTH (CHAIN_LEN)
  ) u_rsp_shreg (
    .clk_i      (CLK),
    .rst_ni     (RSTB),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (rsp_shift),
    .sin_i      (SO),
    .q_o        (rsp_q),
    .sout_o     (rsp_sout)
  );

  // Only the pattern serial output and the lower response bits feed logic.
  assign unused_bits = ^{pat_q, rsp_q[CHAIN_LEN-1], rsp_sout};

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      se_q     <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (abort_act) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            se_q    <= 1'b1;
            si_q    <= pattern[CHAIN_LEN-1];
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt_last) begin
            state_q <= ST_CAPTURE;
            cnt_q   <= '0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            si_q  <= pat_sout;
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_UNLOAD;
          cnt_q   <= '0;
          se_q    <= 1'b1;
          si_q    <= 1'b0;
        end
        ST_UNLOAD: begin
          if (cnt_last) begin
            state_q  <= ST_DONE;
            cnt_q    <= '0;
            se_q     <= 1'b0;
            done_q   <= 1'b1;
            // Final SO sample merged here so result is whole while done is high;
            // result_q is untouched by aborted sequences.
            result_q <= {rsp_q[CHAIN_LEN-2:0], SO};
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          se_q    <= 1'b0;
          si_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          se_q    <= 1'b0;
          si_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SE     = se_q;
  assign SI     = si_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-flop scan chain model.
// Each chain flop's functional D is (Q & keep_m) ^ xor_m, so a constant D
// (keep=0) and a hold D (keep=all ones) are both special cases; the expected
// response of a full sequence is therefore (pattern & keep) ^ xor.
module tb_scan_chain_ctrl;

  localparam int unsigned N = 8;

  logic         CLK = 1'b0;
  logic         RSTB;
  logic         start;
  logic         abort;
  logic [N-1:0] pattern;
  logic         SO;
  logic         SE;
  logic         SI;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  logic [N-1:0] chain_q = '0;
  logic [N-1:0] keep_m;
  logic [N-1:0] xor_m;
  logic [N-1:0] exp_result;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 CLK = ~CLK;

  scan_chain_ctrl #(
    .CHAIN_LEN (N)
  ) dut (
    .CLK     (CLK),
    .RSTB    (RSTB),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .SO      (SO),
    .SE      (SE),
    .SI      (SI),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // Scan chain: flop 0 nearest SI, flop N-1 drives SO.
  always @(posedge CLK) begin
    if (SE) chain_q <= {chain_q[N-2:0], SI};
    else    chain_q <= (chain_q & keep_m) ^ xor_m;
  end
  assign SO = chain_q[N-1];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_se"},   SE,   1'b0);
    chk1({tag, "_si"},   SI,   1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chkv({tag, "_result"}, result, exp_result);
  endtask

  // mode: 0 quiet, 1 random start/pattern noise while busy,
  //       2 start held high throughout, 3 abort high together with start.
  // Entered in an IDLE cycle; returns in the IDLE cycle after DONE.
  task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] keep,
                         input logic [N-1:0] xm, input int mode);
    logic [N-1:0] want;
    logic         exp_se;
    logic         exp_si;
    want   = (pat & keep) ^ xm;
    keep_m = keep;
    xor_m  = xm;
    pattern = pat;
    start   = 1'b1;
    abort   = (mode == 3);
    tick();
    abort = 1'b0;
    for (int c = 1; c <= 2 * N + 2; c++) begin
      exp_se = ((c >= 1) && (c <= N)) || ((c >= N + 2) && (c <= 2 * N + 1));
      exp_si = 1'b0;
      if (c <= N) exp_si = pat[N - c];
      chk1("seq_se",   SE,   exp_se);
      chk1("seq_si",   SI,   exp_si);
      chk1("seq_busy", busy, 1'b1);
      chk1("seq_done", done, (c == 2 * N + 2));
      if (c == 2 * N + 2) begin
        chkv("seq_result", result, want);
        exp_result = want;
      end else begin
        chkv("seq_result_hold", result, exp_result);
      end
      if (mode == 2)      start = 1'b1;
      else if (mode == 1) start = 1'($urandom % 2);
      else                start = 1'b0;
      pattern = N'($urandom);
      tick();
    end
    start = (mode == 2);
    chk_idle("post_done");
  endtask

  // Abort raised during cycle ac of a sequence.
  task automatic abort_seq(input logic [N-1:0] pat, input int ac);
    pattern = pat;
    start   = 1'b1;
    abort   = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= ac; c++) begin
      chk1("ab_busy", busy, 1'b1);
      if (c == ac) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    chk_idle("ab_idle");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1("ab_nodone", done, 1'b0);
      chk1("ab_stay_idle", busy, 1'b0);
    end
  endtask

  // RSTB dropped during cycle rc of a sequence.
  task automatic reset_mid(input logic [N-1:0] pat, input int rc);
    pattern = pat;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < rc; c++) tick();
    RSTB = 1'b0;
    tick();
    exp_result = '0;
    chk_idle("rst_mid");
    RSTB = 1'b1;
    tick();
    chk1("rst_mid_nodone", done, 1'b0);
    chk1("rst_mid_idle", busy, 1'b0);
  endtask

  initial begin
    RSTB       = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    pattern    = '0;
    keep_m     = '0;
    xor_m      = 8'hA5;
    exp_result = '0;
    tick();
    tick();
    chk_idle("reset");
    RSTB = 1'b1;
    tick();
    chk_idle("after_reset");

    // Constant D = A5, pattern 3C.
    run_seq(8'h3C, 8'h00, 8'hA5, 0);
    // Hold D: response equals the loaded pattern.
    run_seq(8'h96, 8'hFF, 8'h00, 0);
    // start held high: one done, restart on the first IDLE cycle.
    run_seq(8'h5A, 8'h0F, 8'h33, 2);
    run_seq(8'hC3, 8'hFF, 8'h00, 0);
    // abort and start together in IDLE: start wins.
    run_seq(8'h81, 8'hF0, 8'h0F, 3);
    // Abort in UNLOAD cycle 12, then in the last UNLOAD cycle and in SHIFT.
    abort_seq(8'h12, 12);
    abort_seq(8'hE7, 2 * N + 1);
    abort_seq(8'h4B, 1);
    run_seq(8'h69, 8'hFF, 8'h00, 0);
    // Reset during SHIFT cycle 5, then a normal sequence.
    reset_mid(8'h77, 5);
    run_seq(8'h3C, 8'h00, 8'hA5, 0);

    for (int i = 0; i < 16; i++) begin
      run_seq(N'($urandom), N'($urandom), N'($urandom), (i % 4 == 3) ? 3 : 1);
    end
    for (int i = 0; i < 6; i++) begin
      abort_seq(N'($urandom), int'($urandom_range(1, 2 * N + 1)));
      run_seq(N'($urandom), N'($urandom), N'($urandom), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 Parameter: CHAIN_LEN, default 16, number of scan flops (SDFFX1/SDFFARX1) in the controlled chain; legal range 2..256.
REQ-002 Parameter: CNT_W, default $clog2(CHAIN_LEN+1), bit-counter width; derived, never overridden.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 CLK  input  1  sole clock; all state updates on the posedge.
REQ-005 RSTB  input  1  synchronous active-low reset.
REQ-006 start  input  1  request a load/capture/unload sequence; sampled only in IDLE.
REQ-007 abort  input  1  terminate the current sequence; no done pulse.
REQ-008 pattern  input  CHAIN_LEN  stimulus to load; bit j targets chain flop j (flop 0 nearest SI).
REQ-009 SO  input  1  Q of the last chain flop (flop CHAIN_LEN-1).
REQ-010 SE  output  1  scan enable to every chain flop; registered.
REQ-011 SI  output  1  scan input to flop 0; registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when result is valid.
REQ-014 result  output  CHAIN_LEN  captured response; bit j = value captured by flop j.

Function
REQ-015 States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
REQ-016 IDLE: SE=0, SI=0. When start=1, latch pattern into an internal shift register, clear the bit counter and go to SHIFT. Change pattern freely after the start cycle.
REQ-017 SHIFT: exactly CHAIN_LEN cycles, SE=1. Drive SI=pattern[CHAIN_LEN-1-k] in shift cycle k (MSB first), so flop j ends holding pattern[j]. Then go to CAPTURE.
REQ-018 CAPTURE: exactly one cycle, SE=0, SI=0, so the chain flops load their functional D inputs.
REQ-019 UNLOAD: exactly CHAIN_LEN cycles, SE=1, SI=0. In unload cycle k, sample SO into result[CHAIN_LEN-1-k]. Then go to DONE.
REQ-020 DONE: one cycle, done=1, SE=0. result is complete and stays stable until the next accepted start. Next state is IDLE.
REQ-021 Latency: the start-sampling edge is cycle 0. SHIFT occupies cycles 1..N, CAPTURE cycle N+1, UNLOAD cycles N+2..2N+1, and done=1 in cycle 2N+2 (N=CHAIN_LEN).
REQ-022 start while busy is ignored and not queued.
REQ-023 start in the DONE cycle is ignored. The earliest accepted restart is the first IDLE cycle, so back-to-back sequences are separated by one IDLE cycle.
REQ-024 abort=1 in any non-IDLE state: next cycle is IDLE, SE=0, no done, result unchanged from its prior value.
REQ-025 abort and start both high in IDLE: start wins; abort has no effect in IDLE.
REQ-026 The bit counter saturates at CHAIN_LEN-1 and never wraps inside a state. It is cleared on every state entry.

Reset
REQ-027 RSTB=0 at a posedge forces, at that edge: state=IDLE, SE=0, SI=0, done=0, busy=0, result=0, counter=0, pattern shift register=0.
REQ-028 Reset mid-sequence (any state) behaves as REQ-027; no done pulse, partially unloaded result discarded.
REQ-029 No asynchronous reset paths exist; RSTB is used only inside the clocked process.

Structure
REQ-030 Shared package scan_ctrl_pkg holds the state enum (scan_state_t) and encoding constants. CNT_W is derived locally.
REQ-031 One sub-module: scan_shreg, a CHAIN_LEN-bit parallel-load/serial-out register with enable, instanced twice (pattern out, response in).
REQ-032 All outputs come directly from flops; no combinational path from any input to any output.

Verification
REQ-033 Bench chain: 8 SDFFX1 flops with D tied to 8'hA5; CHAIN_LEN=8. pattern=8'h3C, start pulse -> SI sequence 0,0,1,1,1,1,0,0 with SE=1 in cycles 1..8; SE=0 in cycle 9; done in cycle 18; result=8'hA5.
REQ-034 Same chain, D wired as Q of the same flop (hold). pattern=8'h96 -> result=8'h96, proving load ordering.
REQ-035 start re-asserted every cycle during a sequence -> only one done in 18 cycles. Next sequence starts on the cycle after DONE+1.
REQ-036 abort in cycle 12 (UNLOAD) -> IDLE at cycle 13, SE=0, no done, result equals the previous sequence's value.
REQ-037 RSTB=0 in cycle 5 (SHIFT) -> next cycle all outputs 0, state IDLE. A new start after RSTB=1 completes normally with result=8'hA5.
